// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: TX byte FIFO, RX holding register, status and timer.
// The free-running timer and CTRL.timer_en exist only when IO_TIMER_EN is defined.
module io_bus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          WIN_BITS  = 5,
  parameter int          TX_DEPTH  = 8,
  parameter int          CNT_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        IoSel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int OFF_W = WIN_BITS - 2;

  localparam logic [OFF_W-1:0] OFF_TXDATA = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_RXDATA = OFF_W'(2);
  localparam logic [OFF_W-1:0] OFF_CTRL   = OFF_W'(3);
  localparam logic [OFF_W-1:0] OFF_TIMER  = OFF_W'(4);

  // stage p0: address decode and store strobes
  logic [OFF_W-1:0] word_p0;
  logic             wr_p0;
  logic             push_p0;
  logic             ctrl_wr_p0;
  logic             timer_wr_p0;
  logic             flush_p0;
  logic             ack_p0;
  logic             ovf_clr_p0;

  assign IoSel       = (DataAdr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign word_p0     = DataAdr[WIN_BITS-1:2];
  assign wr_p0       = MemWrite && IoSel;
  assign push_p0     = wr_p0 && (word_p0 == OFF_TXDATA);
  assign ctrl_wr_p0  = wr_p0 && (word_p0 == OFF_CTRL);
  assign timer_wr_p0 = wr_p0 && (word_p0 == OFF_TIMER);
  assign flush_p0    = ctrl_wr_p0 && WriteData[1];
  assign ack_p0      = ctrl_wr_p0 && WriteData[0];
  assign ovf_clr_p0  = ctrl_wr_p0 && WriteData[3];

  logic unused_bits;
  assign unused_bits = ^{DataAdr[1:0], WriteData[31:8], WriteData[2]};

  // TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] tx_count;
  logic             tx_ovf;
  logic             tx_full;
  logic             tx_pop;
  logic             tx_push_ok;
  logic             tx_ovf_set;

  assign tx_valid   = (tx_count != '0);
  assign tx_full    = (tx_count == CNT_W'(TX_DEPTH));
  assign tx_pop     = tx_valid && tx_ready && !flush_p0;
  // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
  assign tx_push_ok = push_p0 && !flush_p0 && (!tx_full || tx_pop);
  assign tx_ovf_set = push_p0 && !flush_p0 && tx_full && !tx_pop;
  assign tx_data    = tx_valid ? tx_mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tx_count <= '0;
    end else if (flush_p0) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (tx_pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({tx_push_ok, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_W'(1);
        2'b01:   tx_count <= tx_count - CNT_W'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           tx_ovf <= 1'b0;
    else if (tx_ovf_set) tx_ovf <= 1'b1;
    else if (ovf_clr_p0) tx_ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[wr_ptr] <= WriteData[7:0];
  end

  // RX holding register
  logic       rx_full;
  logic [7:0] rx_byte;
  logic       rx_accept;

  assign rx_ready  = !rx_full;
  assign rx_accept = rx_valid && !rx_full;

  always_ff @(posedge clk) begin
    if (reset)          rx_full <= 1'b0;
    else if (rx_accept) rx_full <= 1'b1;
    else if (ack_p0)    rx_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rx_accept) rx_byte <= rx_data;
  end

  // Timer
  logic [31:0] timer_val;
  logic        timer_en;

`ifdef IO_TIMER_EN
  always_ff @(posedge clk) begin
    if (reset)           timer_en <= 1'b0;
    else if (ctrl_wr_p0) timer_en <= WriteData[2];
  end

  always_ff @(posedge clk) begin
    if (reset)            timer_val <= '0;
    else if (timer_wr_p0) timer_val <= WriteData;
    else if (timer_en)    timer_val <= timer_val + 32'd1;
  end
`else
  logic unused_timer;
  assign unused_timer = timer_wr_p0;
  assign timer_en     = 1'b0;
  assign timer_val    = '0;
`endif

  // Read mux
  logic [31:0] status_p0;
  logic [31:0] rmux_p0;

  always_comb begin
    status_p0              = '0;
    status_p0[0]           = tx_full;
    status_p0[1]           = !tx_valid;
    status_p0[2]           = rx_full;
    status_p0[3]           = tx_ovf;
    status_p0[8 +: CNT_W]  = tx_count;
  end

  always_comb begin
    rmux_p0 = '0;
    case (word_p0)
      OFF_STATUS: rmux_p0 = status_p0;
      OFF_RXDATA: rmux_p0 = {24'h0, rx_byte};
      OFF_CTRL:   rmux_p0 = {29'h0, timer_en, 2'b00};
      OFF_TIMER:  rmux_p0 = timer_val;
      default:    rmux_p0 = '0;
    endcase
  end

  // stage p1: registered load data, one cycle behind the address
  logic [31:0] read_p1;

  always_ff @(posedge clk) begin
    if (reset)      read_p1 <= '0;
    else if (IoSel) read_p1 <= rmux_p0;
    else            read_p1 <= '0;
  end

  assign ReadData = read_p1;

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Memory-mapped I/O responder on the ARM core's data bus (DataAdr / WriteData / MemWrite / ReadData), sitting beside the data RAM.
- Claims a small address window and serves it with:
  - a TX byte FIFO drained by an external stream consumer;
  - a single-byte RX holding register filled by an external producer;
  - a status register and a free-running 32-bit timer.
- ReadData timing matches the data RAM: registered, one-cycle latency. Top-level muxes ReadData using IoSel.

Parameters:
- BASE_ADDR, 32'h0000_1000, window base; must be aligned to 2^WIN_BITS.
- WIN_BITS, 5, window size in address bits (32 bytes, 8 words).
- TX_DEPTH, 8, TX FIFO entries; must be a power of 2 and ≥ 2.
- CNT_W, 4, width of the TX occupancy count; must satisfy 2^CNT_W > TX_DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- DataAdr  in  32  CPU data byte address.
- WriteData  in  32  CPU store data.
- MemWrite  in  1  CPU store strobe.
- ReadData  out  32  load data, registered, valid the cycle after the address.
- IoSel  out  1  combinational: DataAdr lies inside the window.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  consumer accepts the head byte.
- rx_data  in  8  producer byte.
- rx_valid  in  1  producer byte valid.
- rx_ready  out  1  holding register empty.

Behaviour:
- Decode:
  - IoSel = (DataAdr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]).
  - Word offset = DataAdr[WIN_BITS-1:2]; DataAdr[1:0] ignored.
  - A store acts only when MemWrite && IoSel.
- Register map (word offsets):
  - 0 TXDATA: W pushes WriteData[7:0]; R returns 0.
  - 1 STATUS (R only):
    - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 tx_overflow (sticky);
    - bits[8+CNT_W-1:8] TX occupancy; all other bits 0.
  - 2 RXDATA: R returns {24'b0, held byte}. Reads have no side-effect.
  - 3 CTRL:
    - W: bit0 rx_ack (clears rx_full), bit1 tx_flush, bit2 timer_en (level, stored), bit3 clear tx_overflow.
    - R: {29'b0, timer_en, 2'b0}.
  - 4 TIMER: R returns counter; W loads WriteData.
  - 5..7: R returns 0; W ignored.
- ReadData:
  - Registered every cycle from the decode of the current DataAdr.
  - Registered value is 0 when IoSel is low.
- TX FIFO:
  - Circular buffer with read/write pointers and an occupancy count.
  - tx_data = head entry; tx_valid = count != 0.
  - Pop on tx_valid && tx_ready.
  - Push when full: data dropped, tx_overflow set, count unchanged.
  - Push and pop in the same cycle: both take effect, count unchanged. This also holds when full, because a pop frees the slot first and no overflow is flagged.
  - tx_flush: pointers and count go to 0 and any same-cycle pop is cancelled. tx_overflow is not cleared by flush.
  - Pointers wrap modulo TX_DEPTH.
- RX:
  - rx_ready = !rx_full.
  - Accept on rx_valid && rx_ready: byte latched, rx_full set.
  - rx_ack while rx_full == 0 has no effect.
  - Because rx_ready is low while full, accept and ack cannot collide.
- Timer:
  - Increments by 1 per cycle while timer_en is set; wraps 0xFFFF_FFFF to 0.
  - A TIMER write in the same cycle wins over the increment.
- Reset (synchronous, overrides everything including a same-cycle store):
  - FIFO empty and tx_overflow cleared.
  - rx_full cleared and rx_ready high.
  - timer = 0 and timer_en = 0.
  - ReadData = 0, tx_valid = 0, tx_data = 0.
  - Reset mid-transfer discards FIFO contents and the held RX byte.

Optional Feature:
- Macro IO_TIMER_EN.
- Defined: timer and CTRL bit2 behave as above.
- Undefined:
  - No counter logic; TIMER reads 0 and writes to it are ignored.
  - CTRL bit2 is ignored and reads 0.
  - All other behaviour is unchanged.

Test Plan:
- Reset, then load BASE+4 → next-cycle ReadData = 0x0000_0002 (tx_empty); tx_valid = 0; rx_ready = 1.
- Store 0x41, 0x42, 0x43 to BASE+0 with tx_ready = 0; STATUS = 0x0000_0300. Raise tx_ready → tx_data sequence 0x41, 0x42, 0x43, then tx_valid falls.
- Fill 8 bytes, then a 9th push → STATUS bit0 = 1, bit3 = 1, count 8; the 9th byte never appears. Store 0x8 to BASE+12 → bit3 clears. Push concurrent with a pop while full → count stays 8, no overflow.
- Drive rx_data = 0x5A with rx_valid → rx_ready falls; RXDATA reads 0x5A; a second byte 0x77 is held off. Store 0x1 to BASE+12 → rx_ready rises, 0x77 latched.
- (IO_TIMER_EN) Store 0xFFFF_FFFE to BASE+16, then 0x4 to BASE+12 → TIMER reads wrap through 0xFFFF_FFFF to 0x0000_0000. Reset mid-count → TIMER = 0, timer_en = 0.
- Store to 0x0000_2000 (outside the window) → IoSel = 0, no FIFO push; ReadData = 0.
